rominit_router: RTL and testbench
=================================

// Module: rominit_router
// PURPOSE
//  Parametrised ROM-download router. It accepts one byte stream (hps/ioctl or bench file), packs it into DATA_W words and steers them to one of NUM_REGIONS ROM images.
//  Region examples: boot, chr, apu, cart.
//  It generalises the fixed 8-bit, four-select ROMINIT bus with output width, region count, size limits, flow control and per-region load status.
//  It sits between the download source and the scv ROMINIT_* inputs.
// PARAMETERS
//  NUM_REGIONS  4      number of ROM regions; one-hot select width
//  DATA_W       8      output word width; must be 8, 16 or 32
//  ADDR_W       25     output word-address width
//  MAX_BYTES    2**20  per-transfer byte limit; bytes past it are dropped
//  PAD_BYTE     8'hFF  fill value for unused byte lanes of a final partial word
// PORTS
//  CLK            in   1            system clock
//  RES            in   1            synchronous reset, active-high
//  IN_SEL         in   $clog2(NUM_REGIONS)  region index; sampled on the first byte of a transfer
//  IN_DATA        in   8            stream byte
//  IN_VALID       in   1            byte valid
//  IN_LAST        in   1            last byte of transfer; qualified by IN_VALID
//  IN_READY       out  1            byte accepted when IN_VALID & IN_READY
//  ROMINIT_SEL    out  NUM_REGIONS  one-hot target region; 0 when idle
//  ROMINIT_ADDR   out  ADDR_W       word address within region, from 0
//  ROMINIT_DATA   out  DATA_W       packed word, little-endian
//  ROMINIT_VALID  out  1            word valid
//  ROMINIT_READY  in   1            sink accepts the word when VALID & READY
//  LOADED         out  NUM_REGIONS  sticky: a region's transfer completed
//  OVERFLOW       out  NUM_REGIONS  sticky: a region's transfer exceeded MAX_BYTES
//  BUSY           out  1            transfer in progress
// BEHAVIOUR
//  Reset values:
//   - All outputs 0, except IN_READY = 1 and ROMINIT_ADDR = 0.
//   - Byte counter, lane counter and partial word are cleared.
//  FSM states: IDLE, FILL, EMIT, FLUSH.
//   - IDLE -> FILL on the first accepted byte. IN_SEL is latched into cur_sel and BUSY goes 1.
//   - FILL: each accepted byte goes to lane k. Byte k occupies bits [8k+7:8k]. BPW = DATA_W/8.
//   - FILL -> EMIT when lane BPW-1 is filled, or IN_LAST arrives on an accepted in-limit byte.
//   - EMIT: ROMINIT_VALID = 1, registered, asserted the cycle after the completing byte.
//     SEL, ADDR and DATA stay stable until READY.
//   - IN_READY = 0 in EMIT and FLUSH. No skid buffer.
//   - On VALID & READY: ADDR increments by 1 and lanes clear.
//     Next state is FILL, or FLUSH if the word held LAST.
//   - FLUSH, one cycle: LOADED[cur_sel] is set, ADDR returns to 0, SEL goes 0, BUSY goes 0, state returns to IDLE.
//  Partial final word: unfilled lanes get PAD_BYTE. It is emitted like a full word.
//  Overflow:
//   - Bytes with byte_count >= MAX_BYTES are accepted (IN_READY stays 1) and discarded.
//   - OVERFLOW[cur_sel] is set on the first dropped byte.
//   - A pending partial word is emitted when LAST arrives.
//   - LAST on a dropped byte with no lanes filled goes straight to FLUSH.
//  Byte counter is $clog2(MAX_BYTES)+1 bits and saturates at MAX_BYTES. ADDR wraps modulo 2**ADDR_W.
//  Mid-transfer IN_SEL changes are ignored until the next IDLE.
//  IN_LAST on the first byte: a 1-byte transfer. One padded word is emitted at ADDR 0.
//  Back-to-back transfers: after FLUSH, the next transfer may target any region.
//   - LOADED and OVERFLOW bits of other regions are preserved.
//   - Reloading a region clears neither bit; only RES does.
//  RES mid-transfer:
//   - The next cycle shows the reset values, including LOADED = OVERFLOW = 0.
//   - ROMINIT_VALID drops with no handshake, and the partial word is lost.
//  Sustained rate with ROMINIT_READY tied 1: BPW bytes per BPW+1 cycles.
// TESTING
//  1. DATA_W=8: stream 00..0F to region 3 with READY=1.
//     -> SEL=4'b1000, ADDR 0..15, DATA = byte, LOADED=4'b1000.
//  2. DATA_W=16: bytes 11,22,33 with LAST on 33.
//     -> words 16'h2211 @0 and 16'hFF33 @1, then LOADED set.
//  3. DATA_W=32, READY low for 5 cycles on word 0.
//     -> VALID, ADDR and DATA held; IN_READY=0 throughout; no byte lost.
//  4. MAX_BYTES=4, DATA_W=8: send 6 bytes.
//     -> 4 words emitted, OVERFLOW[sel]=1, LOADED[sel]=1, IN_READY never low in FILL.
//  5. Load region 0, then region 2. -> LOADED=4'b0101; ADDR restarts at 0 for region 2.
//  6. Assert RES after 3 bytes of a DATA_W=32 transfer.
//     -> next cycle VALID=0, BUSY=0, LOADED=0; a fresh transfer starts at ADDR 0.

Source files
------------

// File: rtl/rominit_router.sv
// Packs a byte stream into DATA_W words and steers them to one of NUM_REGIONS ROM images, with sticky per-region load/overflow status.
// Latency: a word is presented on ROMINIT_* the cycle after its completing byte; FLUSH adds one cycle at the end of a transfer.
// Backpressure: IN_READY is low while a word waits for ROMINIT_READY and during FLUSH; there is no skid buffer.
module rominit_router #(
    parameter int         NUM_REGIONS = 4,
    parameter int         DATA_W      = 8,
    parameter int         ADDR_W      = 25,
    parameter int         MAX_BYTES   = 2**20,
    parameter logic [7:0] PAD_BYTE    = 8'hFF,
    localparam int        SEL_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic                   CLK,
    input  logic                   RES,
    input  logic [SEL_W-1:0]       IN_SEL,
    input  logic [7:0]             IN_DATA,
    input  logic                   IN_VALID,
    input  logic                   IN_LAST,
    output logic                   IN_READY,
    output logic [NUM_REGIONS-1:0] ROMINIT_SEL,
    output logic [ADDR_W-1:0]      ROMINIT_ADDR,
    output logic [DATA_W-1:0]      ROMINIT_DATA,
    output logic                   ROMINIT_VALID,
    input  logic                   ROMINIT_READY,
    output logic [NUM_REGIONS-1:0] LOADED,
    output logic [NUM_REGIONS-1:0] OVERFLOW,
    output logic                   BUSY
);

    localparam int BPW    = DATA_W / 8;
    localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int CNT_W  = $clog2(MAX_BYTES) + 1;

    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_BYTES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BPW - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_EMIT  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t                 state_q,    state_d;
    logic [SEL_W-1:0]       cur_sel_q,  cur_sel_d;
    logic                   busy_q,     busy_d;
    logic                   valid_q,    valid_d;
    logic                   last_q,     last_d;
    logic [ADDR_W-1:0]      addr_q,     addr_d;
    logic [DATA_W-1:0]      word_q,     word_d;
    logic [LANE_W-1:0]      lane_q,     lane_d;
    logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic [NUM_REGIONS-1:0] loaded_q,   loaded_d;
    logic [NUM_REGIONS-1:0] overflow_q, overflow_d;

    logic                   in_ready;
    logic                   in_limit;
    logic                   emit;
    logic [SEL_W-1:0]       sel_eff;
    logic [LANE_W:0]        filled;

    // State register; reset wipes the transfer and the sticky status alike.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q    <= S_IDLE;
            cur_sel_q  <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            addr_q     <= '0;
            word_q     <= '0;
            lane_q     <= '0;
            byte_cnt_q <= '0;
            loaded_q   <= '0;
            overflow_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_sel_q  <= cur_sel_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            lane_q     <= lane_d;
            byte_cnt_q <= byte_cnt_d;
            loaded_q   <= loaded_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state logic: byte packing, overflow dropping, word handshake and end-of-transfer flush.
    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        last_d     = last_q;
        addr_d     = addr_q;
        word_d     = word_q;
        lane_d     = lane_q;
        byte_cnt_d = byte_cnt_q;
        loaded_d   = loaded_q;
        overflow_d = overflow_q;
        emit       = 1'b0;
        filled     = '0;

        in_ready = (state_q == S_IDLE) || (state_q == S_FILL);
        in_limit = (byte_cnt_q < MAX_CNT);
        // The region is taken from IN_SEL only on the first byte; later changes are ignored.
        sel_eff  = (state_q == S_IDLE) ? IN_SEL : cur_sel_q;

        case (state_q)
            S_IDLE, S_FILL: begin
                if (IN_VALID) begin
                    cur_sel_d = sel_eff;
                    busy_d    = 1'b1;
                    state_d   = S_FILL;
                    if (in_limit) begin
                        word_d[8*int'(lane_q) +: 8] = IN_DATA;
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        filled     = {1'b0, lane_q} + (LANE_W+1)'(1);
                        if ((lane_q == LAST_LANE) || IN_LAST) begin
                            emit = 1'b1;
                        end else begin
                            lane_d = lane_q + LANE_W'(1);
                        end
                    end else begin
                        // Past the limit: swallow the byte but remember the region overflowed.
                        overflow_d[sel_eff] = 1'b1;
                        filled = {1'b0, lane_q};
                        if (IN_LAST) begin
                            if (lane_q != '0) begin
                                emit = 1'b1;
                            end else begin
                                state_d = S_FLUSH;
                            end
                        end
                    end
                    if (emit) begin
                        // Lanes the stream never reached are filled with the pad byte.
                        for (int k = 0; k < BPW; k++) begin
                            if (k >= int'(filled)) begin
                                word_d[8*k +: 8] = PAD_BYTE;
                            end
                        end
                        state_d = S_EMIT;
                        valid_d = 1'b1;
                        last_d  = IN_LAST;
                    end
                end
            end
            S_EMIT: begin
                if (ROMINIT_READY) begin
                    valid_d = 1'b0;
                    addr_d  = addr_q + ADDR_W'(1);
                    word_d  = '0;
                    lane_d  = '0;
                    state_d = last_q ? S_FLUSH : S_FILL;
                end
            end
            S_FLUSH: begin
                loaded_d[cur_sel_q] = 1'b1;
                addr_d     = '0;
                busy_d     = 1'b0;
                last_d     = 1'b0;
                byte_cnt_d = '0;
                lane_d     = '0;
                word_d     = '0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign IN_READY      = in_ready;
    assign ROMINIT_SEL   = busy_q ? (NUM_REGIONS'(1) << cur_sel_q) : '0;
    assign ROMINIT_ADDR  = addr_q;
    assign ROMINIT_DATA  = word_q;
    assign ROMINIT_VALID = valid_q;
    assign LOADED        = loaded_q;
    assign OVERFLOW      = overflow_q;
    assign BUSY          = busy_q;

endmodule

// File: tb/tb_rominit_router.sv
// Bench for rominit_router: four instances (8-bit, 8-bit with MAX_BYTES=4, 16-bit with MAX_BYTES=7, 32-bit).
// Directed steps then random transfers, each compared word-by-word against a byte-list packing model.
// Sink backpressure is either held fixed or randomised every cycle.
`timescale 1ns/1ps
module tb_rominit_router;

    typedef struct packed {
        logic [3:0]  sel;
        logic [24:0] addr;
        logic [31:0] dat;
    } obs_t;

    logic        clk;
    logic        res;
    logic [1:0]  in_sel;
    logic [7:0]  in_data;
    logic        in_last;
    logic [3:0]  in_vld;
    logic [3:0]  rdy_fix;
    logic [3:0]  rnd_bits;
    logic        rdy_rand;
    wire  [3:0]  rom_rdy;

    wire  [3:0]  in_rdy_o;
    wire  [3:0]  vld_o;
    wire  [3:0]  busy_o;
    wire  [3:0]  sel_o    [0:3];
    wire  [24:0] addr_o   [0:3];
    wire  [3:0]  loaded_o [0:3];
    wire  [3:0]  ovf_o    [0:3];
    wire  [31:0] dat_o    [0:3];
    wire  [7:0]  d0;
    wire  [7:0]  d1;
    wire  [15:0] d2;
    wire  [31:0] d3;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          bpw_of [4] = '{1, 1, 2, 4};
    int          max_of [4] = '{1 << 20, 4, 7, 1 << 20};
    logic [3:0]  loaded_m [4];
    logic [3:0]  ovf_m    [4];
    logic [7:0]  tx [$];
    int          stall_q [$];
    obs_t        obs_q [$];

    assign dat_o[0] = {24'h0, d0};
    assign dat_o[1] = {24'h0, d1};
    assign dat_o[2] = {16'h0, d2};
    assign dat_o[3] = d3;
    assign rom_rdy  = rdy_rand ? rnd_bits : rdy_fix;

    rominit_router #(.NUM_REGIONS(4), .DATA_W(8), .ADDR_W(25), .MAX_BYTES(2**20), .PAD_BYTE(8'hFF)) u_d8 (
        .CLK(clk), .RES(res), .IN_SEL(in_sel), .IN_DATA(in_data), .IN_VALID(in_vld[0]), .IN_LAST(in_last),
        .IN_READY(in_rdy_o[0]), .ROMINIT_SEL(sel_o[0]), .ROMINIT_ADDR(addr_o[0]), .ROMINIT_DATA(d0),
        .ROMINIT_VALID(vld_o[0]), .ROMINIT_READY(rom_rdy[0]), .LOADED(loaded_o[0]), .OVERFLOW(ovf_o[0]), .BUSY(busy_o[0]));

    rominit_router #(.NUM_REGIONS(4), .DATA_W(8), .ADDR_W(25), .MAX_BYTES(4), .PAD_BYTE(8'hFF)) u_d8m (
        .CLK(clk), .RES(res), .IN_SEL(in_sel), .IN_DATA(in_data), .IN_VALID(in_vld[1]), .IN_LAST(in_last),
        .IN_READY(in_rdy_o[1]), .ROMINIT_SEL(sel_o[1]), .ROMINIT_ADDR(addr_o[1]), .ROMINIT_DATA(d1),
        .ROMINIT_VALID(vld_o[1]), .ROMINIT_READY(rom_rdy[1]), .LOADED(loaded_o[1]), .OVERFLOW(ovf_o[1]), .BUSY(busy_o[1]));

    rominit_router #(.NUM_REGIONS(4), .DATA_W(16), .ADDR_W(25), .MAX_BYTES(7), .PAD_BYTE(8'hFF)) u_d16 (
        .CLK(clk), .RES(res), .IN_SEL(in_sel), .IN_DATA(in_data), .IN_VALID(in_vld[2]), .IN_LAST(in_last),
        .IN_READY(in_rdy_o[2]), .ROMINIT_SEL(sel_o[2]), .ROMINIT_ADDR(addr_o[2]), .ROMINIT_DATA(d2),
        .ROMINIT_VALID(vld_o[2]), .ROMINIT_READY(rom_rdy[2]), .LOADED(loaded_o[2]), .OVERFLOW(ovf_o[2]), .BUSY(busy_o[2]));

    rominit_router #(.NUM_REGIONS(4), .DATA_W(32), .ADDR_W(25), .MAX_BYTES(2**20), .PAD_BYTE(8'hFF)) u_d32 (
        .CLK(clk), .RES(res), .IN_SEL(in_sel), .IN_DATA(in_data), .IN_VALID(in_vld[3]), .IN_LAST(in_last),
        .IN_READY(in_rdy_o[3]), .ROMINIT_SEL(sel_o[3]), .ROMINIT_ADDR(addr_o[3]), .ROMINIT_DATA(d3),
        .ROMINIT_VALID(vld_o[3]), .ROMINIT_READY(rom_rdy[3]), .LOADED(loaded_o[3]), .OVERFLOW(ovf_o[3]), .BUSY(busy_o[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) rnd_bits <= 4'($urandom);

    // Record every word handshake of whichever instance is active.
    always @(posedge clk) begin
        if (!res) begin
            for (int i = 0; i < 4; i++) begin
                if (vld_o[i] && rom_rdy[i]) obs_q.push_back({sel_o[i], addr_o[i], dat_o[i]});
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        res = 1'b1;
        repeat (2) @(posedge clk);
        #1 res = 1'b0;
        for (int i = 0; i < 4; i++) begin
            loaded_m[i] = 4'h0;
            ovf_m[i]    = 4'h0;
        end
    endtask

    task automatic send(input int d, input logic [7:0] b, input logic last, input logic [1:0] sel);
        int st;
        st = 0;
        in_sel    = sel;
        in_data   = b;
        in_last   = last;
        in_vld[d] = 1'b1;
        while (!in_rdy_o[d] && st < 200) begin
            @(posedge clk); #1;
            st++;
        end
        chk("in_ready", in_rdy_o[d], 1'b1);
        @(posedge clk); #1;
        in_vld[d] = 1'b0;
        in_last   = 1'b0;
        stall_q.push_back(st);
    endtask

    task automatic wait_idle(input int d);
        int g;
        g = 0;
        while (busy_o[d] && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        chk("busy_done", busy_o[d], 1'b0);
    endtask

    // Model: keep the first MAX_BYTES bytes, chunk into BPW-byte little-endian words, pad the tail with FF.
    task automatic check_xfer(input int d, input int sel);
        int n, kept, bpw, nw, idx;
        logic [31:0] e;
        logic [7:0]  b;
        n    = tx.size();
        bpw  = bpw_of[d];
        kept = (n < max_of[d]) ? n : max_of[d];
        nw   = (kept + bpw - 1) / bpw;
        chk("word_count", obs_q.size(), nw);
        for (int w = 0; w < nw; w++) begin
            e = 32'h0;
            for (int k = 0; k < bpw; k++) begin
                idx = w * bpw + k;
                b   = (idx < kept) ? tx[idx] : 8'hFF;
                e   = e | (32'(b) << (8 * k));
            end
            if (w < obs_q.size()) begin
                chk("word_addr", obs_q[w].addr, w);
                chk("word_data", obs_q[w].dat, e);
                chk("word_sel", obs_q[w].sel, 4'b0001 << sel);
            end
        end
        loaded_m[d][sel] = 1'b1;
        if (n > max_of[d]) ovf_m[d][sel] = 1'b1;
        chk("loaded", loaded_o[d], loaded_m[d]);
        chk("overflow", ovf_o[d], ovf_m[d]);
        chk("idle_sel", sel_o[d], 4'h0);
        chk("idle_addr", addr_o[d], 25'h0);
        chk("idle_ready", in_rdy_o[d], 1'b1);
    endtask

    task automatic xfer(input int d, input int sel);
        obs_q.delete();
        stall_q.delete();
        for (int i = 0; i < tx.size(); i++) begin
            send(d, tx[i], i == tx.size() - 1, (i == 0) ? 2'(sel) : 2'($urandom_range(0, 3)));
        end
        wait_idle(d);
        check_xfer(d, sel);
    endtask

    task automatic fill_random(input int n);
        tx.delete();
        for (int i = 0; i < n; i++) tx.push_back(8'($urandom));
    endtask

    initial begin
        res      = 1'b1;
        in_sel   = 2'd0;
        in_data  = 8'h0;
        in_last  = 1'b0;
        in_vld   = 4'h0;
        rdy_fix  = 4'hF;
        rdy_rand = 1'b0;
        do_reset();

        // Reset state of every instance.
        for (int i = 0; i < 4; i++) begin
            chk("rst_in_ready", in_rdy_o[i], 1'b1);
            chk("rst_valid", vld_o[i], 1'b0);
            chk("rst_busy", busy_o[i], 1'b0);
            chk("rst_sel", sel_o[i], 4'h0);
            chk("rst_addr", addr_o[i], 25'h0);
            chk("rst_data", dat_o[i], 32'h0);
            chk("rst_loaded", loaded_o[i], 4'h0);
            chk("rst_overflow", ovf_o[i], 4'h0);
        end

        // 8-bit: bytes 00..0F to region 3.
        tx.delete();
        for (int i = 0; i < 16; i++) tx.push_back(8'(i));
        xfer(0, 3);
        chk("t1_loaded", loaded_o[0], 4'b1000);

        // 16-bit: 11,22,33 -> 2211, FF33.
        tx = '{8'h11, 8'h22, 8'h33};
        xfer(2, 1);
        chk("t2_word0", (obs_q.size() > 0) ? obs_q[0].dat : 32'hDEAD, 32'h2211);
        chk("t2_word1", (obs_q.size() > 1) ? obs_q[1].dat : 32'hDEAD, 32'hFF33);

        // 32-bit: sink stalls for 5 cycles on word 0.
        fill_random(8);
        obs_q.delete();
        rdy_fix[3] = 1'b0;
        for (int i = 0; i < 4; i++) send(3, tx[i], 1'b0, 2'd2);
        for (int c = 0; c < 5; c++) begin
            chk("t3_valid_held", vld_o[3], 1'b1);
            chk("t3_addr_held", addr_o[3], 25'h0);
            chk("t3_data_held", dat_o[3], {tx[3], tx[2], tx[1], tx[0]});
            chk("t3_in_ready_low", in_rdy_o[3], 1'b0);
            @(posedge clk); #1;
        end
        rdy_fix[3] = 1'b1;
        for (int i = 4; i < 8; i++) send(3, tx[i], i == 7, 2'd0);
        wait_idle(3);
        check_xfer(3, 2);

        // MAX_BYTES=4: six bytes, last two dropped.
        fill_random(6);
        xfer(1, 1);
        chk("t4_overflow", ovf_o[1], 4'b0010);
        chk("t4_emit_stall", stall_q[4], 1);
        chk("t4_drop_no_stall", stall_q[5], 0);

        // Region 0 then region 2 from a clean reset.
        do_reset();
        fill_random(5);
        xfer(2, 0);
        fill_random(4);
        xfer(2, 2);
        chk("t5_loaded", loaded_o[2], 4'b0101);

        // 32-bit: reset after 3 bytes of a transfer.
        fill_random(4);
        xfer(3, 2);
        fill_random(3);
        obs_q.delete();
        for (int i = 0; i < 3; i++) send(3, tx[i], 1'b0, 2'd1);
        res = 1'b1;
        @(posedge clk); #1;
        chk("t6_valid", vld_o[3], 1'b0);
        chk("t6_busy", busy_o[3], 1'b0);
        chk("t6_loaded", loaded_o[3], 4'h0);
        chk("t6_overflow", ovf_o[3], 4'h0);
        chk("t6_addr", addr_o[3], 25'h0);
        chk("t6_in_ready", in_rdy_o[3], 1'b1);
        res = 1'b0;
        for (int i = 0; i < 4; i++) begin
            loaded_m[i] = 4'h0;
            ovf_m[i]    = 4'h0;
        end
        chk("t6_no_word", obs_q.size(), 0);
        fill_random(6);
        xfer(3, 1);

        // Random transfers with random sink backpressure.
        rdy_rand = 1'b1;
        for (int d = 0; d < 4; d++) begin
            for (int t = 0; t < 6; t++) begin
                fill_random($urandom_range(1, 12));
                xfer(d, $urandom_range(0, 3));
            end
        end
        rdy_rand = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
